// File: rtl/alpaca_ospfb_utils_pkg.sv
// Shared types and constants for the OSPFB test/bring-up blocks.
// Holds the sample-source pattern enum, default sizes and the PRBS LFSR step.
package alpaca_ospfb_utils_pkg;

  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    IMPULSE = 2'd1,
    CONST   = 2'd2,
    PRBS    = 2'd3
  } src_mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } src_state_t;

  localparam int          SRC_WIDTH     = 16;
  localparam int          SRC_FFT_LEN   = 64;
  localparam int          SRC_NFRM_WID  = 16;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ospfb_lfsr16.sv
// 16-bit Galois LFSR with synchronous load; load takes priority over advance.
module ospfb_lfsr16
  import alpaca_ospfb_utils_pkg::*;
#(
  parameter logic [15:0] RST_SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstn)     state <= RST_SEED;
    else if (load) state <= seed;
    else if (en)   state <= lfsr16_next(state);
  end

endmodule

// File: rtl/ospfb_axis_sample_src.sv
// AXI4-Stream framed sample generator (ramp / impulse / constant / PRBS) feeding
// the OSPFB input. All outputs are registered and advance only on acceptance.
module ospfb_axis_sample_src
  import alpaca_ospfb_utils_pkg::*;
#(
  parameter int          WIDTH     = SRC_WIDTH,
  parameter int          FFT_LEN   = SRC_FFT_LEN,
  parameter int          NFRM_WID  = SRC_NFRM_WID,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  localparam int         IDX_W     = $clog2(FFT_LEN)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                stop,
  input  src_mode_t           mode,
  input  logic [WIDTH-1:0]    amp,
  input  logic [IDX_W-1:0]    imp_idx,
  input  logic [NFRM_WID-1:0] nframes,
  output logic [WIDTH-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(FFT_LEN - 1);

  src_state_t          state_q, state_d;
  src_mode_t           mode_q, mode_d;
  logic [WIDTH-1:0]    amp_q, amp_d;
  logic [IDX_W-1:0]    imp_idx_q, imp_idx_d;
  logic [NFRM_WID-1:0] nframes_q, nframes_d;
  logic [IDX_W-1:0]    beat_q, beat_d, beat_nxt;
  logic [NFRM_WID-1:0] frame_q, frame_d;
  logic [WIDTH-1:0]    ramp_q, ramp_d, ramp_nxt;
  logic                stop_pend_q, stop_pend_d;
  logic [WIDTH-1:0]    tdata_d;
  logic                tvalid_d, tlast_d, done_d;
  logic                lfsr_en, lfsr_load;
  logic [15:0]         lfsr_state;
  logic                accept, final_frame;

  ospfb_lfsr16 #(.RST_SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (lfsr_en),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  // Sample value for a given beat; the caller supplies next-beat counters so the
  // result can be registered straight into the output stage.
  function automatic logic [WIDTH-1:0] pattern(
    input src_mode_t        m,
    input logic [WIDTH-1:0] a,
    input logic [IDX_W-1:0] ii,
    input logic [IDX_W-1:0] b,
    input logic [WIDTH-1:0] r,
    input logic [15:0]      l
  );
    logic [WIDTH+15:0] ext;
    ext = {{WIDTH{1'b0}}, l};
    case (m)
      RAMP:    return r;
      IMPULSE: return (b == ii) ? a : '0;
      CONST:   return a;
      default: return ext[WIDTH-1:0];
    endcase
  endfunction

  assign accept      = m_axis_tvalid & m_axis_tready;
  assign final_frame = (nframes_q != '0) && (frame_q == nframes_q - NFRM_WID'(1));
  assign beat_nxt    = beat_q + IDX_W'(1);
  assign ramp_nxt    = ramp_q + WIDTH'(1);
  assign busy        = (state_q == S_RUN);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    amp_d       = amp_q;
    imp_idx_d   = imp_idx_q;
    nframes_d   = nframes_q;
    beat_d      = beat_q;
    frame_d     = frame_q;
    ramp_d      = ramp_q;
    stop_pend_d = stop_pend_q;
    tdata_d     = m_axis_tdata;
    tvalid_d    = m_axis_tvalid;
    tlast_d     = m_axis_tlast;
    done_d      = 1'b0;
    lfsr_en     = 1'b0;
    lfsr_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          mode_d      = mode;
          amp_d       = amp;
          imp_idx_d   = imp_idx;
          nframes_d   = nframes;
          beat_d      = '0;
          frame_d     = '0;
          ramp_d      = '0;
          stop_pend_d = 1'b0;
          lfsr_load   = 1'b1;
          tvalid_d    = 1'b1;
          tlast_d     = 1'b0;
          tdata_d     = pattern(mode, amp, imp_idx, '0, '0, LFSR_SEED);
        end
      end
      default: begin
        if (stop) stop_pend_d = 1'b1;
        if (accept) begin
          lfsr_en = 1'b1;
          if (m_axis_tlast) frame_d = frame_q + NFRM_WID'(1);
          // A stop arriving with the last beat still ends the run there.
          if (m_axis_tlast && (stop_pend_q || stop || final_frame)) begin
            state_d     = S_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            beat_d  = beat_nxt;
            ramp_d  = ramp_nxt;
            tlast_d = (beat_nxt == LAST_BEAT);
            tdata_d = pattern(mode_q, amp_q, imp_idx_q, beat_nxt, ramp_nxt,
                              lfsr16_next(lfsr_state));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      mode_q        <= RAMP;
      amp_q         <= '0;
      imp_idx_q     <= '0;
      nframes_q     <= '0;
      beat_q        <= '0;
      frame_q       <= '0;
      ramp_q        <= '0;
      stop_pend_q   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      amp_q         <= amp_d;
      imp_idx_q     <= imp_idx_d;
      nframes_q     <= nframes_d;
      beat_q        <= beat_d;
      frame_q       <= frame_d;
      ramp_q        <= ramp_d;
      stop_pend_q   <= stop_pend_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_ospfb_axis_sample_src.sv
// Directed self-checking bench for ospfb_axis_sample_src (WIDTH=16, FFT_LEN=64).
module tb_ospfb_axis_sample_src;
  import alpaca_ospfb_utils_pkg::*;

  localparam int          WIDTH    = 16;
  localparam int          FFT_LEN  = 64;
  localparam int          NFRM_WID = 16;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic                clk = 1'b0;
  logic                rstn;
  logic                start, stop;
  src_mode_t           mode;
  logic [WIDTH-1:0]    amp;
  logic [5:0]          imp_idx;
  logic [NFRM_WID-1:0] nframes;
  logic [WIDTH-1:0]    m_axis_tdata;
  logic                m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic                busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  src_mode_t        cur_mode;
  logic [WIDTH-1:0] cur_amp;
  int               cur_imp;

  logic [15:0] prbs_gold [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};

  ospfb_axis_sample_src #(
    .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .NFRM_WID(NFRM_WID), .LFSR_SEED(SEED)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .amp           (amp),
    .imp_idx       (imp_idx),
    .nframes       (nframes),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Independent bitwise model of the x^16+x^14+x^13+x^11+1 Galois LFSR.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  task automatic do_start(input src_mode_t m, input logic [15:0] a, input int i,
                          input logic [15:0] n, input logic with_stop);
    mode = m; amp = a; imp_idx = 6'(i); nframes = n;
    start = 1'b1; stop = with_stop; m_axis_tready = 1'b1;
    cur_mode = m; cur_amp = a; cur_imp = i;
    cycle();
    start = 1'b0; stop = 1'b0;
    // Scramble inputs so only the latched configuration can produce the expected data.
    mode = src_mode_t'(~m); amp = ~a; imp_idx = ~imp_idx; nframes = ~n;
  endtask

  // Run nbeats with tready=1, checking every beat against the bench model.
  task automatic stream(input string tag, input int nbeats, input int stop_at,
                        input int start_at, input bit expect_end);
    logic [15:0] lm;
    logic [15:0] e;
    int          b;
    lm = SEED;
    e  = '0;
    for (int g = 0; g < nbeats; g++) begin
      b = g % FFT_LEN;
      case (cur_mode)
        RAMP:    e = 16'(g);
        IMPULSE: e = (b == cur_imp) ? cur_amp : 16'h0;
        CONST:   e = cur_amp;
        default: e = lm;
      endcase
      if (cur_mode == PRBS && g < 4) check({tag, "_gold"}, m_axis_tdata, prbs_gold[g]);
      check({tag, "_data"}, m_axis_tdata, e);
      check({tag, "_last"}, m_axis_tlast, (b == FFT_LEN - 1));
      check({tag, "_valid"}, m_axis_tvalid, 1);
      check({tag, "_done_low"}, done, 0);
      if (g == 0) check({tag, "_busy"}, busy, 1);
      m_axis_tready = 1'b1;
      stop  = (g == stop_at);
      start = (g == start_at);
      if (g == start_at) begin
        mode = RAMP; amp = 16'h0; nframes = 16'd1;
      end
      cycle();
      stop = 1'b0; start = 1'b0;
      lm = model_step(lm);
    end
    if (expect_end) begin
      check({tag, "_end_valid"}, m_axis_tvalid, 0);
      check({tag, "_end_last"}, m_axis_tlast, 0);
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_end_done"}, done, 1);
      check({tag, "_end_hold"}, m_axis_tdata, e);
      cycle();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_valid"}, m_axis_tvalid, 0);
    end
  endtask

  initial begin
    logic [15:0] exp_n;
    bit          stalled, seen_done;

    rstn = 1'b0; start = 1'b0; stop = 1'b0; mode = RAMP; amp = '0;
    imp_idx = '0; nframes = '0; m_axis_tready = 1'b0;
    cur_mode = RAMP; cur_amp = '0; cur_imp = 0;
    cycle(); cycle();
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_data", m_axis_tdata, 0);
    check("rst_last", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    cycle();
    check("idle_valid", m_axis_tvalid, 0);

    // 1: RAMP, two frames
    do_start(RAMP, 16'h0, 0, 16'd2, 1'b0);
    stream("t1", 128, -1, -1, 1'b1);

    // 2: IMPULSE at beat 5, three frames
    do_start(IMPULSE, 16'h7FFF, 5, 16'd3, 1'b0);
    stream("t2", 192, -1, -1, 1'b1);

    // 3: RAMP under random back-pressure
    do_start(RAMP, 16'h0, 0, 16'd2, 1'b0);
    exp_n = '0; stalled = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        seen_done = 1'b1;
        check("t3_end_valid", m_axis_tvalid, 0);
        break;
      end
      if (stalled) check("t3_stall_valid", m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        check("t3_data", m_axis_tdata, exp_n);
        check("t3_last", m_axis_tlast, (exp_n[5:0] == 6'd63));
      end
      m_axis_tready = ($urandom_range(0, 1) == 1);
      stalled = m_axis_tvalid & ~m_axis_tready;
      if (m_axis_tvalid && m_axis_tready) exp_n = exp_n + 16'd1;
      cycle();
    end
    check("t3_done_seen", seen_done, 1);
    check("t3_count", exp_n, 128);
    m_axis_tready = 1'b1;

    // 4: CONST run-forever, ignored start at beat 100, stop at beat 20 of frame 3
    do_start(CONST, 16'h1234, 0, 16'd0, 1'b0);
    stream("t4", 256, 3 * 64 + 20, 100, 1'b1);

    // 4b: start+stop together in IDLE, fresh ramp, stop coinciding with frame-1 last beat
    do_start(RAMP, 16'h0, 0, 16'd0, 1'b1);
    stream("t4b", 128, 127, -1, 1'b1);

    // 5: PRBS against the bench model, stop inside frame 15
    do_start(PRBS, 16'h0, 0, 16'd0, 1'b0);
    stream("t5", 1024, 1000, -1, 1'b1);

    // 6: reset mid-frame while stalled
    do_start(RAMP, 16'h0, 0, 16'd0, 1'b0);
    stream("t6a", 10, -1, -1, 1'b0);
    m_axis_tready = 1'b0;
    cycle(); cycle();
    check("t6_stall_data", m_axis_tdata, 10);
    check("t6_stall_valid", m_axis_tvalid, 1);
    rstn = 1'b0;
    cycle();
    check("t6_rst_valid", m_axis_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_data", m_axis_tdata, 0);
    rstn = 1'b1;
    cycle();
    check("t6_post_done", done, 0);
    check("t6_post_valid", m_axis_tvalid, 0);
    do_start(RAMP, 16'h0, 0, 16'd1, 1'b0);
    stream("t6b", 64, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
